// File: rtl/hazard_ctrl_if.sv
// Hazard-unit bus: decode/execute/memory hazard inputs and the stall/flush controls returned to the pipeline.
// The pipeline side uses the master modport and hazard_ctrl uses the slave modport.
interface hazard_ctrl_if #(
  parameter int REG_SELECT = 5
);
  logic [REG_SELECT-1:0] i_reg_a_select_D;
  logic [REG_SELECT-1:0] i_reg_b_select_D;
  logic [REG_SELECT-1:0] i_reg_c_select_E;
  logic                  i_uses_a_D;
  logic                  i_uses_b_D;
  logic                  i_is_load_E;
  logic                  i_branch_taken_E;
  logic                  i_mem_req_M;
  logic                  i_mem_ready_M;
  logic                  o_stall_F;
  logic                  o_stall_D;
  logic                  o_stall_E;
  logic                  o_stall_M;
  logic                  o_flush_D;
  logic                  o_flush_E;
  logic                  o_mem_timeout;
  logic [31:0]           o_stall_count;

  modport master (
    output i_reg_a_select_D, i_reg_b_select_D, i_reg_c_select_E,
    output i_uses_a_D, i_uses_b_D, i_is_load_E, i_branch_taken_E,
    output i_mem_req_M, i_mem_ready_M,
    input  o_stall_F, o_stall_D, o_stall_E, o_stall_M,
    input  o_flush_D, o_flush_E, o_mem_timeout, o_stall_count
  );

  modport slave (
    input  i_reg_a_select_D, i_reg_b_select_D, i_reg_c_select_E,
    input  i_uses_a_D, i_uses_b_D, i_is_load_E, i_branch_taken_E,
    input  i_mem_req_M, i_mem_ready_M,
    output o_stall_F, o_stall_D, o_stall_E, o_stall_M,
    output o_flush_D, o_flush_E, o_mem_timeout, o_stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes and memory-wait stalls with a sticky timeout flag.
// Optional stall-cycle statistics counter enabled by the macro HAZARD_STALL_STATS_EN.
module hazard_ctrl #(
  parameter int REG_SELECT  = 5,
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [2:0]            lu_cnt_r;
  logic [2:0]            lu_cnt_next_s;
  logic [15:0]           wait_cnt_r;
  logic [15:0]           wait_cnt_next_s;
  logic                  timeout_r;
  logic                  timeout_next_s;
  logic [REG_SELECT-1:0] dest_s;
  logic                  lu_hit_s;
  logic                  mem_wait_s;
  logic                  resume_s;
  logic                  stall_fd_s;
  logic                  stall_em_s;
  logic                  flush_d_s;
  logic                  flush_e_s;

  // Hazard detection from the current stage inputs
  always_comb begin
    dest_s     = bus.i_reg_c_select_E;
    lu_hit_s   = bus.i_is_load_E && (dest_s != '0) &&
                 ((bus.i_uses_a_D && (bus.i_reg_a_select_D == dest_s)) ||
                  (bus.i_uses_b_D && (bus.i_reg_b_select_D == dest_s)));
    mem_wait_s = bus.i_mem_req_M && !bus.i_mem_ready_M;
    // A pending bubble count survives a memory wait and resumes on its exit cycle
    resume_s   = (state_r == LU_STALL) || ((state_r == MEM_WAIT) && (lu_cnt_r != 3'd0));
  end

  // Next-state, counter and control decode with priority mem-wait > branch > load-use
  always_comb begin
    state_next_s    = RUN;
    lu_cnt_next_s   = lu_cnt_r;
    wait_cnt_next_s = 16'd0;
    timeout_next_s  = timeout_r;
    stall_fd_s      = 1'b0;
    stall_em_s      = 1'b0;
    flush_d_s       = 1'b0;
    flush_e_s       = 1'b0;
    if (mem_wait_s) begin
      stall_fd_s   = 1'b1;
      stall_em_s   = 1'b1;
      state_next_s = MEM_WAIT;
      if (wait_cnt_r >= 16'(MEM_TIMEOUT)) begin
        wait_cnt_next_s = wait_cnt_r;
      end else begin
        wait_cnt_next_s = wait_cnt_r + 16'd1;
      end
      if (wait_cnt_next_s >= 16'(MEM_TIMEOUT)) begin
        timeout_next_s = 1'b1;
      end else begin
        timeout_next_s = timeout_r;
      end
    end else if (bus.i_branch_taken_E) begin
      flush_d_s     = 1'b1;
      flush_e_s     = 1'b1;
      lu_cnt_next_s = 3'd0;
      state_next_s  = RUN;
    end else if (resume_s) begin
      stall_fd_s    = 1'b1;
      flush_e_s     = 1'b1;
      lu_cnt_next_s = lu_cnt_r - 3'd1;
      if (lu_cnt_r == 3'd1) begin
        state_next_s = RUN;
      end else begin
        state_next_s = LU_STALL;
      end
    end else if (lu_hit_s) begin
      stall_fd_s = 1'b1;
      flush_e_s  = 1'b1;
      if (LOAD_LAT > 1) begin
        lu_cnt_next_s = 3'(LOAD_LAT - 1);
        state_next_s  = LU_STALL;
      end else begin
        lu_cnt_next_s = 3'd0;
        state_next_s  = RUN;
      end
    end else begin
      state_next_s = RUN;
    end
  end

  // State and counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= RUN;
      lu_cnt_r   <= 3'd0;
      wait_cnt_r <= 16'd0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      lu_cnt_r   <= lu_cnt_next_s;
      wait_cnt_r <= wait_cnt_next_s;
      timeout_r  <= timeout_next_s;
    end
  end

  // Controls are forced low while reset is held
  assign bus.o_stall_F     = i_rst_n & stall_fd_s;
  assign bus.o_stall_D     = i_rst_n & stall_fd_s;
  assign bus.o_stall_E     = i_rst_n & stall_em_s;
  assign bus.o_stall_M     = i_rst_n & stall_em_s;
  assign bus.o_flush_D     = i_rst_n & flush_d_s;
  assign bus.o_flush_E     = i_rst_n & flush_e_s;
  assign bus.o_mem_timeout = timeout_r;

`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] stall_count_r;

  // Saturating count of fetch-stall cycles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_count_r <= 32'd0;
    end else if (stall_fd_s && (stall_count_r != 32'hFFFF_FFFF)) begin
      stall_count_r <= stall_count_r + 32'd1;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign bus.o_stall_count = stall_count_r;
`else
  assign bus.o_stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: one instance with LOAD_LAT=1 and one with LOAD_LAT=3, MEM_TIMEOUT=8.
module tb_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  localparam logic [5:0] IDLE   = 6'b000000;
  localparam logic [5:0] BUBBLE = 6'b110001;
  localparam logic [5:0] MEMW   = 6'b111100;
  localparam logic [5:0] BRANCH = 6'b000011;

  hazard_ctrl_if #(.REG_SELECT(5)) if_a ();
  hazard_ctrl_if #(.REG_SELECT(5)) if_b ();

  hazard_ctrl #(.REG_SELECT(5), .LOAD_LAT(1), .MEM_TIMEOUT(255)) dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if_a)
  );

  hazard_ctrl #(.REG_SELECT(5), .LOAD_LAT(3), .MEM_TIMEOUT(8)) dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order: {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E}
  function automatic logic [5:0] ctl_a();
    return {if_a.o_stall_F, if_a.o_stall_D, if_a.o_stall_E, if_a.o_stall_M, if_a.o_flush_D, if_a.o_flush_E};
  endfunction

  function automatic logic [5:0] ctl_b();
    return {if_b.o_stall_F, if_b.o_stall_D, if_b.o_stall_E, if_b.o_stall_M, if_b.o_flush_D, if_b.o_flush_E};
  endfunction

  task automatic idle_inputs();
    if_a.i_reg_a_select_D = 5'd0; if_a.i_reg_b_select_D = 5'd0; if_a.i_reg_c_select_E = 5'd0;
    if_a.i_uses_a_D = 1'b0; if_a.i_uses_b_D = 1'b0; if_a.i_is_load_E = 1'b0;
    if_a.i_branch_taken_E = 1'b0; if_a.i_mem_req_M = 1'b0; if_a.i_mem_ready_M = 1'b0;
    if_b.i_reg_a_select_D = 5'd0; if_b.i_reg_b_select_D = 5'd0; if_b.i_reg_c_select_E = 5'd0;
    if_b.i_uses_a_D = 1'b0; if_b.i_uses_b_D = 1'b0; if_b.i_is_load_E = 1'b0;
    if_b.i_branch_taken_E = 1'b0; if_b.i_mem_req_M = 1'b0; if_b.i_mem_ready_M = 1'b0;
  endtask

  task automatic load_b(input logic [4:0] dst, input logic [4:0] ra, input logic [4:0] rb,
                        input logic ua, input logic ub);
    if_b.i_is_load_E = 1'b1; if_b.i_reg_c_select_E = dst;
    if_b.i_reg_a_select_D = ra; if_b.i_reg_b_select_D = rb;
    if_b.i_uses_a_D = ua; if_b.i_uses_b_D = ub;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    load_b(5'd3, 5'd3, 5'd0, 1'b1, 1'b0);
    if_b.i_branch_taken_E = 1'b1;
    #1;
    checks++;
    if (ctl_b() !== IDLE) begin
      errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl_b(), IDLE);
    end
    checks++;
    if (if_b.o_mem_timeout !== 1'b0 || if_b.o_stall_count !== 32'd0 || if_a.o_stall_count !== 32'd0) begin
      errors++; $display("FAIL reset_regs timeout=%b count_b=%0d count_a=%0d exp=0", if_b.o_mem_timeout,
                         if_b.o_stall_count, if_a.o_stall_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    #1;
    checks++;
    if (ctl_a() !== IDLE || ctl_b() !== IDLE) begin
      errors++; $display("FAIL idle_after_reset a=%b b=%b exp=%b", ctl_a(), ctl_b(), IDLE);
    end
  endtask

  task automatic test_lu_lat1();
    logic [5:0] exp_v [2] = '{BUBBLE, IDLE};
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if_a.i_is_load_E = (k == 0); if_a.i_reg_c_select_E = 5'd5;
      if_a.i_reg_a_select_D = 5'd5; if_a.i_uses_a_D = 1'b1;
      #1;
      checks++;
      if (ctl_a() !== exp_v[k]) begin
        errors++; $display("FAIL lu_lat1 cyc=%0d got=%b exp=%b", k, ctl_a(), exp_v[k]);
      end
    end
  endtask

  task automatic test_lu_lat3();
    logic [5:0] exp_v [5] = '{BUBBLE, BUBBLE, BUBBLE, IDLE, IDLE};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      idle_inputs();
      if (k == 0) load_b(5'd7, 5'd1, 5'd7, 1'b0, 1'b1);
      if (k == 4) load_b(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
      #1;
      checks++;
      if (ctl_b() !== exp_v[k]) begin
        errors++; $display("FAIL lu_lat3 cyc=%0d got=%b exp=%b", k, ctl_b(), exp_v[k]);
      end
    end
    // a source not actually read must not hit
    @(negedge clk);
    load_b(5'd9, 5'd9, 5'd9, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl_b() !== IDLE) begin
      errors++; $display("FAIL lu_unused_src got=%b exp=%b", ctl_b(), IDLE);
    end
  endtask

  task automatic test_branch();
    logic [5:0] exp_v [5] = '{BRANCH, IDLE, BUBBLE, BRANCH, IDLE};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      idle_inputs();
      if (k == 0) begin load_b(5'd4, 5'd4, 5'd0, 1'b1, 1'b0); if_b.i_branch_taken_E = 1'b1; end
      if (k == 2) load_b(5'd4, 5'd4, 5'd0, 1'b1, 1'b0);
      if (k == 3) if_b.i_branch_taken_E = 1'b1;
      #1;
      checks++;
      if (ctl_b() !== exp_v[k]) begin
        errors++; $display("FAIL branch cyc=%0d got=%b exp=%b", k, ctl_b(), exp_v[k]);
      end
    end
  endtask

  task automatic test_mem_in_lu();
    logic [5:0] exp_v [8] = '{BUBBLE, MEMW, MEMW, MEMW, MEMW, BUBBLE, BUBBLE, IDLE};
    logic [31:0] exp_cnt;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      idle_inputs();
      if (k == 0) load_b(5'd7, 5'd0, 5'd7, 1'b0, 1'b1);
      if (k >= 1 && k <= 5) if_b.i_mem_req_M = 1'b1;
      if (k == 5) if_b.i_mem_ready_M = 1'b1;
      #1;
      checks++;
      if (ctl_b() !== exp_v[k]) begin
        errors++; $display("FAIL mem_in_lu cyc=%0d got=%b exp=%b", k, ctl_b(), exp_v[k]);
      end
    end
`ifdef HAZARD_STALL_STATS_EN
    exp_cnt = 32'd7;
`else
    exp_cnt = 32'd0;
`endif
    checks++;
    if (if_b.o_stall_count !== exp_cnt || if_b.o_mem_timeout !== 1'b0) begin
      errors++; $display("FAIL stall_count got=%0d timeout=%b exp=%0d timeout=0", if_b.o_stall_count,
                         if_b.o_mem_timeout, exp_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      idle_inputs();
      if (k <= 11) if_b.i_mem_req_M = 1'b1;
      if (k == 11) if_b.i_mem_ready_M = 1'b1;
      #1;
      checks++;
      if (ctl_b() !== ((k <= 10) ? MEMW : IDLE) || if_b.o_mem_timeout !== (k >= 9)) begin
        errors++; $display("FAIL timeout cyc=%0d ctl=%b to=%b exp ctl=%b to=%b", k, ctl_b(),
                           if_b.o_mem_timeout, (k <= 10) ? MEMW : IDLE, (k >= 9));
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    @(negedge clk);
    load_b(5'd6, 5'd6, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    idle_inputs();
    if_b.i_mem_req_M = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctl_b() !== IDLE || if_b.o_stall_count !== 32'd0 || if_b.o_mem_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_mid_wait ctl=%b count=%0d to=%b exp 0", ctl_b(), if_b.o_stall_count,
                         if_b.o_mem_timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (ctl_b() !== IDLE) begin
        errors++; $display("FAIL run_after_reset cyc=%0d got=%b exp=%b", k, ctl_b(), IDLE);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_lu_lat1();
    test_lu_lat3();
    test_branch();
    test_mem_in_lu();
    test_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
